// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared encodings and control bundle for the ID/EX control stage.
// Revision : 1.0
// ============================================================================
package ctrl_pkg;

  localparam logic [1:0] MODE_DP    = 2'b00;
  localparam logic [1:0] MODE_MEM   = 2'b01;
  localparam logic [1:0] MODE_BR    = 2'b10;
  localparam logic [1:0] MODE_UNDEF = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic [3:0] cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_enable;
    logic       branch_taken;
    logic       status_update;
    logic       valid;
    logic       undef;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Writing ALU opcodes only; compares and unlisted opcodes return CMD_NOP.
  function automatic logic [3:0] alu_cmd(input logic [3:0] op);
    case (op)
      OP_MOV:  alu_cmd = CMD_MOV;
      OP_MVN:  alu_cmd = CMD_MVN;
      OP_ADD:  alu_cmd = CMD_ADD;
      OP_ADC:  alu_cmd = CMD_ADC;
      OP_SUB:  alu_cmd = CMD_SUB;
      OP_SBC:  alu_cmd = CMD_SBC;
      OP_AND:  alu_cmd = CMD_AND;
      OP_ORR:  alu_cmd = CMD_ORR;
      OP_EOR:  alu_cmd = CMD_EOR;
      default: alu_cmd = CMD_NOP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ctrl_pipe_if
// Brief    : Decode-side inputs and EX-side controls of the ID/EX control stage.
// Revision : 1.0
// ============================================================================
interface id_ctrl_pipe_if #(
  parameter int CMD_W = 4
);
  logic             freeze;
  logic             flush;
  logic             valid_in;
  logic [1:0]       mode;
  logic [3:0]       opcode;
  logic             s_bit;
  logic [3:0]       cond;
  logic             is_mul;
  logic [3:0]       status;

  logic [CMD_W-1:0] exe_cmd;
  logic             mem_read;
  logic             mem_write;
  logic             wb_enable;
  logic             branch_taken;
  logic             status_update;
  logic             valid_out;
  logic             undef_instr;
  logic             busy;

  modport master (
    output freeze, flush, valid_in, mode, opcode, s_bit, cond, is_mul, status,
    input  exe_cmd, mem_read, mem_write, wb_enable, branch_taken,
           status_update, valid_out, undef_instr, busy
  );

  modport slave (
    input  freeze, flush, valid_in, mode, opcode, s_bit, cond, is_mul, status,
    output exe_cmd, mem_read, mem_write, wb_enable, branch_taken,
           status_update, valid_out, undef_instr, busy
  );
endinterface
`default_nettype wire

// File: rtl/id_ctrl_pipe_cond_check.sv
`default_nettype none
// ============================================================================
// Module   : cond_check
// Brief    : Combinational ARM condition-field evaluation against NZCV.
// Revision : 1.0
// ============================================================================
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = status;

  always_comb begin
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/id_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_ctrl_pipe
// Brief    : Registered decode/control stage with cond check, freeze/flush and
//            a multi-cycle multiply sequencer.
// Revision : 1.0
// ============================================================================
module id_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int CMD_W      = 4,
  parameter int ENABLE_MUL = 1,
  parameter int MUL_CYCLES = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  id_ctrl_pipe_if.slave  bus
);
  localparam int              CNT_W     = $clog2(MUL_CYCLES) + 1;
  localparam bit              MUL_EN    = (ENABLE_MUL != 0);
  localparam bit              MUL_MULTI = MUL_EN && (MUL_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_WAIT = 1'b1;

  logic [0:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  ctrl_t            r_ctrl, w_ctrl_nxt, w_dec;
  logic             w_pass, w_issue, w_mul_start, w_busy;

  cond_check u_cond_check (
    .cond   (bus.cond),
    .status (bus.status),
    .pass   (w_pass)
  );

  always_comb begin
    w_dec       = CTRL_BUBBLE;
    w_dec.valid = 1'b1;
    case (bus.mode)
      MODE_DP: begin
        if (MUL_EN && bus.is_mul) begin
          w_dec.cmd           = CMD_MUL;
          w_dec.wb_enable     = 1'b1;
          w_dec.status_update = bus.s_bit;
        end else if (bus.opcode == OP_CMP) begin
          w_dec.cmd           = CMD_SUB;
          w_dec.status_update = 1'b1;
        end else if (bus.opcode == OP_TST) begin
          w_dec.cmd           = CMD_AND;
          w_dec.status_update = 1'b1;
        end else begin
          // No writing ALU command encodes as 0, so NOP marks an unlisted opcode.
          w_dec.cmd           = alu_cmd(bus.opcode);
          w_dec.wb_enable     = (w_dec.cmd != CMD_NOP);
          w_dec.status_update = bus.s_bit & w_dec.wb_enable;
        end
      end
      MODE_MEM: begin
        w_dec.cmd       = CMD_ADD;
        w_dec.mem_read  = bus.s_bit;
        w_dec.wb_enable = bus.s_bit;
        w_dec.mem_write = !bus.s_bit;
      end
      MODE_BR:  w_dec.branch_taken = 1'b1;
      default:  w_dec.undef        = 1'b1;
    endcase
  end

  assign w_issue     = bus.valid_in & w_pass;
  assign w_mul_start = MUL_MULTI & w_issue & (bus.mode == MODE_DP) & bus.is_mul;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ctrl_nxt  = w_issue ? w_dec : CTRL_BUBBLE;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mul_start) begin
          w_busy      = 1'b1;
          w_ctrl_nxt  = CTRL_BUBBLE;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_MUL_WAIT;
        end
      end
      ST_MUL_WAIT: begin
        // The final cycle issues whatever the held inputs decode to now, so a
        // status change during the wait is honoured.
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_busy     = 1'b1;
          w_ctrl_nxt = CTRL_BUBBLE;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.flush) begin
      w_busy      = 1'b0;
      w_ctrl_nxt  = CTRL_BUBBLE;
      w_cnt_nxt   = '0;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ctrl  <= CTRL_BUBBLE;
    end else if (bus.flush || !bus.freeze) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ctrl  <= w_ctrl_nxt;
    end
  end

  assign bus.exe_cmd       = CMD_W'(r_ctrl.cmd);
  assign bus.mem_read      = r_ctrl.mem_read;
  assign bus.mem_write     = r_ctrl.mem_write;
  assign bus.wb_enable     = r_ctrl.wb_enable;
  assign bus.branch_taken  = r_ctrl.branch_taken;
  assign bus.status_update = r_ctrl.status_update;
  assign bus.valid_out     = r_ctrl.valid;
  assign bus.undef_instr   = r_ctrl.undef;
  assign bus.busy          = w_busy & rst_n;
endmodule
`default_nettype wire

// File: tb/tb_id_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ctrl_pipe
// Brief    : Directed table-driven bench for id_ctrl_pipe (MUL_CYCLES=3).
// Revision : 1.0
// ============================================================================
module tb_id_ctrl_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  id_ctrl_pipe_if #(.CMD_W(4)) bus ();

  id_ctrl_pipe #(.CMD_W(4), .ENABLE_MUL(1), .MUL_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic       valid;
    logic [1:0] mode;
    logic [3:0] op;
    logic       s;
    logic [3:0] cond;
    logic       mul;
    logic [3:0] status;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {cmd, mem_read, mem_write, wb_enable, branch_taken, status_update, valid_out, undef_instr}
  function automatic logic [10:0] mk(input logic [3:0] cmd, input logic mr, input logic mw,
                                     input logic wb, input logic br, input logic su,
                                     input logic vo, input logic ud);
    return {cmd, mr, mw, wb, br, su, vo, ud};
  endfunction

  function automatic logic [10:0] outs();
    return {bus.exe_cmd, bus.mem_read, bus.mem_write, bus.wb_enable, bus.branch_taken,
            bus.status_update, bus.valid_out, bus.undef_instr};
  endfunction

  task automatic add(input string name, input logic valid, input logic [1:0] mode,
                     input logic [3:0] op, input logic s, input logic [3:0] cond,
                     input logic mul, input logic [3:0] status, input logic [10:0] exp);
    vec_t v;
    v.name = name; v.valid = valid; v.mode = mode; v.op = op; v.s = s;
    v.cond = cond; v.mul = mul; v.status = status; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic valid, input logic [1:0] mode, input logic [3:0] op,
                       input logic s, input logic [3:0] cond, input logic mul,
                       input logic [3:0] status);
    bus.valid_in = valid; bus.mode = mode; bus.opcode = op; bus.s_bit = s;
    bus.cond = cond; bus.is_mul = mul; bus.status = status;
  endtask

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_busy(input string name, input logic exp);
    n_tests++;
    if (bus.busy !== exp) begin
      n_fail++;
      $display("FAIL %s: busy got %b expected %b", name, bus.busy, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [10:0] BUB = 11'b0;

  initial begin
    bus.freeze = 1'b0;
    bus.flush  = 1'b0;
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 4'b1110, 1'b0, 4'b0000);

    // Vector table: single-cycle loads, all from IDLE.
    add("add_s_al",   1, 2'b00, 4'b0100, 1, 4'b1110, 0, 4'b0000, mk(4'b0010,0,0,1,0,1,1,0));
    add("sub_eq_z1",  1, 2'b00, 4'b0010, 0, 4'b0000, 0, 4'b0100, mk(4'b0100,0,0,1,0,0,1,0));
    add("sub_eq_z0",  1, 2'b00, 4'b0010, 0, 4'b0000, 0, 4'b0000, BUB);
    add("mov_never",  1, 2'b00, 4'b1101, 0, 4'b1111, 0, 4'b1111, BUB);
    add("mov_al",     1, 2'b00, 4'b1101, 0, 4'b1110, 0, 4'b0000, mk(4'b0001,0,0,1,0,0,1,0));
    add("mvn_s",      1, 2'b00, 4'b1111, 1, 4'b1110, 0, 4'b0000, mk(4'b1001,0,0,1,0,1,1,0));
    add("adc",        1, 2'b00, 4'b0101, 0, 4'b1110, 0, 4'b0000, mk(4'b0011,0,0,1,0,0,1,0));
    add("sbc",        1, 2'b00, 4'b0110, 0, 4'b1110, 0, 4'b0000, mk(4'b0101,0,0,1,0,0,1,0));
    add("and",        1, 2'b00, 4'b0000, 0, 4'b1110, 0, 4'b0000, mk(4'b0110,0,0,1,0,0,1,0));
    add("orr",        1, 2'b00, 4'b1100, 0, 4'b1110, 0, 4'b0000, mk(4'b0111,0,0,1,0,0,1,0));
    add("eor",        1, 2'b00, 4'b0001, 0, 4'b1110, 0, 4'b0000, mk(4'b1000,0,0,1,0,0,1,0));
    add("cmp",        1, 2'b00, 4'b1010, 0, 4'b1110, 0, 4'b0000, mk(4'b0100,0,0,0,0,1,1,0));
    add("tst",        1, 2'b00, 4'b1000, 0, 4'b1110, 0, 4'b0000, mk(4'b0110,0,0,0,0,1,1,0));
    add("unlisted",   1, 2'b00, 4'b0011, 1, 4'b1110, 0, 4'b0000, mk(4'b0000,0,0,0,0,0,1,0));
    add("ldr",        1, 2'b01, 4'b0000, 1, 4'b1110, 0, 4'b0000, mk(4'b0010,1,0,1,0,0,1,0));
    add("str",        1, 2'b01, 4'b0000, 0, 4'b1110, 0, 4'b0000, mk(4'b0010,0,1,0,0,0,1,0));
    add("branch",     1, 2'b10, 4'b0000, 0, 4'b1110, 0, 4'b0000, mk(4'b0000,0,0,0,1,0,1,0));
    add("undef",      1, 2'b11, 4'b0100, 1, 4'b1110, 0, 4'b0000, mk(4'b0000,0,0,0,0,0,1,1));
    add("undef_fail", 1, 2'b11, 4'b0100, 1, 4'b1111, 0, 4'b0000, BUB);
    add("invalid",    0, 2'b00, 4'b0100, 1, 4'b1110, 0, 4'b0000, BUB);
    add("gt_pass",    1, 2'b00, 4'b0100, 0, 4'b1100, 0, 4'b1001, mk(4'b0010,0,0,1,0,0,1,0));
    add("lt_fail",    1, 2'b00, 4'b0100, 0, 4'b1011, 0, 4'b0000, BUB);
    add("hi_pass",    1, 2'b00, 4'b0100, 0, 4'b1000, 0, 4'b0010, mk(4'b0010,0,0,1,0,0,1,0));
    add("ls_fail",    1, 2'b00, 4'b0100, 0, 4'b1001, 0, 4'b0010, BUB);
    add("ne_fail",    1, 2'b00, 4'b0100, 0, 4'b0001, 0, 4'b0100, BUB);
    add("le_pass",    1, 2'b00, 4'b0100, 0, 4'b1101, 0, 4'b1000, mk(4'b0010,0,0,1,0,0,1,0));
    add("mul_fail",   1, 2'b00, 4'b0000, 0, 4'b0000, 1, 4'b0000, BUB);

    // Power-up reset.
    #2 rst_n = 1'b0;
    #1 check("reset_outs", outs(), BUB);
    check_busy("reset_busy", 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].mode, vecs[i].op, vecs[i].s, vecs[i].cond,
            vecs[i].mul, vecs[i].status);
      #1 check_busy({vecs[i].name, "_busy"}, 1'b0);
      tick();
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // Reset mid-stream with ADD in flight; busy must stay low even with MUL on inputs.
    drive(1, 2'b00, 4'b0100, 1, 4'b1110, 0, 4'b0000);
    tick();
    check("midrst_pre", outs(), mk(4'b0010,0,0,1,0,1,1,0));
    drive(1, 2'b00, 4'b0000, 0, 4'b1110, 1, 4'b0000);
    rst_n = 1'b0;
    #1 check("midrst_outs", outs(), BUB);
    check_busy("midrst_busy", 1'b0);
    tick();
    drive(1, 2'b00, 4'b0100, 1, 4'b1110, 0, 4'b0000);
    rst_n = 1'b1;
    tick();
    check("midrst_add", outs(), mk(4'b0010,0,0,1,0,1,1,0));

    // Multiply held for three cycles.
    drive(1, 2'b00, 4'b0000, 0, 4'b1110, 1, 4'b0000);
    #1 check_busy("mul_busy0", 1'b1);
    tick();
    check("mul_out0", outs(), BUB);
    check_busy("mul_busy1", 1'b1);
    tick();
    check("mul_out1", outs(), BUB);
    check_busy("mul_busy2", 1'b0);
    tick();
    check("mul_out2", outs(), mk(4'b1010,0,0,1,0,0,1,0));
    drive(1, 2'b00, 4'b1101, 0, 4'b1110, 0, 4'b0000);
    tick();
    check("after_mul_mov", outs(), mk(4'b0001,0,0,1,0,0,1,0));

    // Flush during the wait aborts the multiply.
    drive(1, 2'b00, 4'b0000, 0, 4'b1110, 1, 4'b0000);
    tick();
    bus.flush = 1'b1;
    #1 check_busy("flush_busy", 1'b0);
    tick();
    check("flush_out", outs(), BUB);
    bus.flush = 1'b0;
    drive(1, 2'b00, 4'b1101, 0, 4'b1110, 0, 4'b0000);
    #1 check_busy("flush_idle", 1'b0);
    tick();
    check("flush_mov", outs(), mk(4'b0001,0,0,1,0,0,1,0));

    // Status change during the wait: EQ passes at entry, fails at issue.
    drive(1, 2'b00, 4'b0000, 1, 4'b0000, 1, 4'b0100);
    tick();
    tick();
    bus.status = 4'b0000;
    tick();
    check("mul_late_fail", outs(), BUB);
    drive(1, 2'b00, 4'b0100, 0, 4'b1110, 0, 4'b0000);
    tick();

    // Freeze holds a loaded CMP; flush wins over freeze.
    drive(1, 2'b00, 4'b1010, 0, 4'b1110, 0, 4'b0000);
    tick();
    check("frz_load", outs(), mk(4'b0100,0,0,0,0,1,1,0));
    bus.freeze = 1'b1;
    drive(1, 2'b00, 4'b0100, 1, 4'b1110, 0, 4'b0000);
    tick();
    check("frz_hold1", outs(), mk(4'b0100,0,0,0,0,1,1,0));
    tick();
    check("frz_hold2", outs(), mk(4'b0100,0,0,0,0,1,1,0));
    bus.flush = 1'b1;
    tick();
    check("frz_flush", outs(), BUB);
    bus.flush  = 1'b0;
    bus.freeze = 1'b0;
    tick();
    check("frz_release", outs(), mk(4'b0010,0,0,1,0,1,1,0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
